alu_exec_stage: RTL and testbench
=================================

# alu_exec_stage

Execute/write-back stage of the 16-bit RISC core, placed directly upstream of the general-purpose register file. It accepts one decoded instruction at a time over a valid/ready handshake. It drives the register file's two read addresses, computes the result (single-cycle ALU ops or an iterative 16-step multiply), and commits it through the register file's write port (`WEN`/`WrtDst`/`WriteData`). It also maintains the Z/N/C status flags.

## Interface
Parameters:
- `width`, 16 (from `gP`): datapath width.
- `rowData`, 8 (from `gP`): register count; addresses are 3 b.

Ports:
- `CLK`  in  1  rising-edge clock
- `RST_N`  in  1  asynchronous, active-low reset
- `IN_VLD`  in  1  decoded instruction valid
- `IN_RDY`  out  1  stage can accept (high only in IDLE)
- `OPC`  in  4  opcode (`gP::opc_t`)
- `DST`  in  3  destination register
- `SA1`, `SA2`  in  3  source register addresses
- `RegS1`, `RegS2`  out  3  read addresses to register file (registered)
- `S1_Out`, `S2_Out`  in  width  register file read data (combinational from `RegS1`/`RegS2`)
- `WEN`  out  1  register file write enable
- `WrtDst`  out  3  write address
- `WriteData`  out  width  write data
- `FLAG_Z`, `FLAG_N`, `FLAG_C`  out  1  status flags
- `DONE`  out  1  one-cycle pulse when an instruction retires
- `ILL`  out  1  one-cycle pulse when an illegal opcode retires

## Operation
- Opcodes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOT 5 (~S1), SHL 6 (S1<<1), SHR 7 (S1>>1, logical), MUL 8 (low 16 b of S1*S2, unsigned), MOV 9 (S1), CMP A (S1−S2, flags only), NOP F. Codes B–E are illegal: they execute as NOP and pulse `ILL`.
- FSM states: IDLE, EXEC, MUL, WB.
  - IDLE: `IN_RDY`=1. When `IN_VLD`&&`IN_RDY`, latch OPC/DST, load `RegS1`←SA1 and `RegS2`←SA2, and go to EXEC.
  - EXEC: read `S1_Out`/`S2_Out`. For a non-MUL op, register the result and flags, then go to WB. For MUL, load the multiplicand, multiplier and a 32-bit accumulator (cleared to 0), set step count 0, and go to MUL.
  - MUL: each cycle, if multiplier bit0 then acc += multiplicand<<step. The count increments each cycle. After the 16th step (count 15), go to WB.
  - WB: `WEN`=1 for exactly one cycle unless the op is CMP, NOP or illegal. `DONE`=1. Go to IDLE.
- Flags update only for arithmetic, logic, shift and MUL ops. NOP, MOV and illegal ops leave all flags unchanged.
  - Z = (result==0). N = result[15].
  - C = carry-out for ADD; borrow (S1<S2 unsigned) for SUB/CMP; the bit shifted out for SHL/SHR; |acc[31:16] for MUL; 0 for logic ops.
- Arithmetic wraps modulo 2^16. A write to any register index, including 0, is legal.

## Timing
- Reset (async, `RST_N`=0): state IDLE; `RegS1`, `RegS2`, `WrtDst`, `WriteData` all 0; `WEN`, `DONE`, `ILL` 0; flags 0. Reset asserted in any state aborts the instruction with no write.
- Non-MUL op accepted at edge k: EXEC during cycle k..k+1; WB during k+1..k+2, with the write landing at edge k+2; `IN_RDY` high again after edge k+2. Latency 3 cycles; throughput 1 per 3 cycles.
- MUL: accept at edge k, then EXEC 1 cycle, MUL 16 cycles, WB 1 cycle, so the write lands at edge k+18.
- Execution is strictly serial, so a source register always reflects the previous instruction's write. No forwarding is needed.
- `IN_VLD` outside IDLE is ignored. The upstream stage holds the instruction until it sees `IN_RDY`.
- `WEN`, `WrtDst` and `WriteData` are all held stable and registered for the whole WB cycle.

## Structure
- Package `gP` (shared) holds `width`, `rowData`, `typedef enum logic [3:0] opc_t`, and `typedef enum logic [1:0] exst_t` (IDLE/EXEC/MUL/WB).
- Sub-module `alu16`: combinational single-cycle ALU (S1, S2, opc → result, c). The FSM, multiplier and flags stay in `alu_exec_stage`.

## Test plan
- Reset then ADD r3←r1+r2 with r1=0x0005, r2=0x0007 → `WEN` pulses 2 cycles after accept, `WrtDst`=3, `WriteData`=0x000C, Z=0, C=0, `DONE`=1.
- ADD 0xFFFF+0x0001 → `WriteData`=0x0000, Z=1, C=1, N=0. Then SUB 0x0001−0x0002 → 0xFFFF, N=1, C=1.
- MUL 0x0100×0x0100 → write at accept+18 with 0x0000, C=1, Z=1. Then MUL 0x0003×0x0005 → 0x000F, C=0. `IN_RDY`=0 throughout.
- CMP r1,r1 → no `WEN`, Z=1, `DONE`=1. OPC=0xC → no `WEN`, `ILL`=1, flags unchanged.
- `IN_VLD` held high during MUL with a different instruction → it is ignored until IDLE, then accepted exactly once.
- `RST_N` low during step 8 of MUL → `WEN` never asserts, all outputs 0, `IN_RDY`=1 after release.

Source files
------------

// File: rtl/alu_exec_stage_pkg.sv
// Shared definitions for the execute/write-back stage of the 16-bit RISC core:
// datapath sizes, opcode and FSM state encodings, and opcode classification helpers.
package gP;

  localparam int width   = 16;
  localparam int rowData = 8;
  localparam int addrW   = $clog2(rowData);
  localparam int stepW   = $clog2(width);

  typedef enum logic [3:0] {
    OPC_ADD = 4'h0,
    OPC_SUB = 4'h1,
    OPC_AND = 4'h2,
    OPC_OR  = 4'h3,
    OPC_XOR = 4'h4,
    OPC_NOT = 4'h5,
    OPC_SHL = 4'h6,
    OPC_SHR = 4'h7,
    OPC_MUL = 4'h8,
    OPC_MOV = 4'h9,
    OPC_CMP = 4'hA,
    OPC_NOP = 4'hF
  } opc_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_WB   = 2'd3
  } exst_t;

  // Codes B..E are unassigned; they retire like NOP but raise ILL.
  function automatic logic isIllegal(input logic [3:0] opc);
    return (opc >= 4'hB) && (opc <= 4'hE);
  endfunction

  function automatic logic writesReg(input logic [3:0] opc);
    return !(isIllegal(opc) || (opc == OPC_CMP) || (opc == OPC_NOP));
  endfunction

  function automatic logic updatesFlags(input logic [3:0] opc);
    return !(isIllegal(opc) || (opc == OPC_NOP) || (opc == OPC_MOV));
  endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Instruction handshake plus register-file read/write ports of the execute stage.
// Handshake: an instruction transfers on a rising CLK edge where IN_VLD && IN_RDY;
// upstream holds OPC/DST/SA1/SA2 stable while IN_VLD is high and IN_RDY is low.
interface alu_exec_stage_if;
  import gP::*;

  logic             IN_VLD;
  logic             IN_RDY;
  logic [3:0]       OPC;
  logic [addrW-1:0] DST;
  logic [addrW-1:0] SA1;
  logic [addrW-1:0] SA2;
  logic [addrW-1:0] RegS1;
  logic [addrW-1:0] RegS2;
  logic [width-1:0] S1_Out;
  logic [width-1:0] S2_Out;
  logic             WEN;
  logic [addrW-1:0] WrtDst;
  logic [width-1:0] WriteData;

  modport slave (
    input  IN_VLD, OPC, DST, SA1, SA2, S1_Out, S2_Out,
    output IN_RDY, RegS1, RegS2, WEN, WrtDst, WriteData
  );

  modport master (
    output IN_VLD, OPC, DST, SA1, SA2, S1_Out, S2_Out,
    input  IN_RDY, RegS1, RegS2, WEN, WrtDst, WriteData
  );

endinterface

// File: rtl/alu_exec_stage_alu16.sv
// Combinational single-cycle ALU. CMP shares the SUB datapath; MUL is handled
// by the iterative multiplier in the stage, so it falls to the default here.
module alu16
  import gP::*;
(
  input  logic [width-1:0] s1,
  input  logic [width-1:0] s2,
  input  logic [3:0]       opc,
  output logic [width-1:0] result,
  output logic             carry
);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (opc)
      OPC_ADD: {carry, result} = {1'b0, s1} + {1'b0, s2};
      OPC_SUB,
      OPC_CMP: begin
        result = s1 - s2;
        carry  = (s1 < s2);
      end
      OPC_AND: result = s1 & s2;
      OPC_OR:  result = s1 | s2;
      OPC_XOR: result = s1 ^ s2;
      OPC_NOT: result = ~s1;
      OPC_SHL: begin
        result = {s1[width-2:0], 1'b0};
        carry  = s1[width-1];
      end
      OPC_SHR: begin
        result = {1'b0, s1[width-1:1]};
        carry  = s1[0];
      end
      OPC_MOV: result = s1;
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute/write-back stage: accepts one decoded instruction, reads the register
// file, runs a single-cycle ALU op or a 16-step shift-add multiply, and commits.
module alu_exec_stage
  import gP::*;
(
  input  logic            CLK,
  input  logic            RST_N,
  alu_exec_stage_if.slave bus,
  output logic            FLAG_Z,
  output logic            FLAG_N,
  output logic            FLAG_C,
  output logic            DONE,
  output logic            ILL,
  output exst_t           dbgState
);

  exst_t              state, nextState;
  logic [3:0]         opcR;
  logic [addrW-1:0]   dstR, regS1R, regS2R, wrtDstR;
  logic [width-1:0]   writeDataR, mcand, mplier, aluRes;
  logic [2*width-1:0] acc, accNext;
  logic [stepW-1:0]   step;
  logic               aluC, wenR, doneR, illR, accept, lastStep;

  assign accept        = bus.IN_VLD && (state == ST_IDLE);
  assign lastStep      = (step == stepW'(width - 1));
  assign bus.IN_RDY    = (state == ST_IDLE);
  assign bus.RegS1     = regS1R;
  assign bus.RegS2     = regS2R;
  assign bus.WEN       = wenR;
  assign bus.WrtDst    = wrtDstR;
  assign bus.WriteData = writeDataR;
  assign DONE          = doneR;
  assign ILL           = illR;
  assign dbgState      = state;

  // One shift-add step: the multiplier is consumed LSB-first as it shifts right.
  assign accNext = mplier[0] ? (acc + ({{width{1'b0}}, mcand} << step)) : acc;

  alu16 uAlu (
    .s1     (bus.S1_Out),
    .s2     (bus.S2_Out),
    .opc    (opcR),
    .result (aluRes),
    .carry  (aluC)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: if (accept) nextState = ST_EXEC;
      ST_EXEC: nextState = (opcR == OPC_MUL) ? ST_MUL : ST_WB;
      ST_MUL:  if (lastStep) nextState = ST_WB;
      ST_WB:   nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  // WEN/DONE/ILL are loaded on the edge entering WB and cleared on the edge leaving it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      opcR       <= OPC_NOP;
      dstR       <= '0;
      regS1R     <= '0;
      regS2R     <= '0;
      wrtDstR    <= '0;
      writeDataR <= '0;
      wenR       <= 1'b0;
      doneR      <= 1'b0;
      illR       <= 1'b0;
      FLAG_Z     <= 1'b0;
      FLAG_N     <= 1'b0;
      FLAG_C     <= 1'b0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      step       <= '0;
    end else begin
      wenR  <= 1'b0;
      doneR <= 1'b0;
      illR  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            opcR   <= bus.OPC;
            dstR   <= bus.DST;
            regS1R <= bus.SA1;
            regS2R <= bus.SA2;
          end
        end
        ST_EXEC: begin
          if (opcR == OPC_MUL) begin
            mcand  <= bus.S1_Out;
            mplier <= bus.S2_Out;
            acc    <= '0;
            step   <= '0;
          end else begin
            wenR       <= writesReg(opcR);
            doneR      <= 1'b1;
            illR       <= isIllegal(opcR);
            wrtDstR    <= dstR;
            writeDataR <= aluRes;
            if (updatesFlags(opcR)) begin
              FLAG_Z <= (aluRes == '0);
              FLAG_N <= aluRes[width-1];
              FLAG_C <= aluC;
            end
          end
        end
        ST_MUL: begin
          acc    <= accNext;
          mplier <= mplier >> 1;
          step   <= step + 1'b1;
          if (lastStep) begin
            wenR       <= 1'b1;
            doneR      <= 1'b1;
            wrtDstR    <= dstR;
            writeDataR <= accNext[width-1:0];
            FLAG_Z     <= (accNext[width-1:0] == '0);
            FLAG_N     <= accNext[width-1];
            FLAG_C     <= |accNext[2*width-1:width];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: a register-file model, a driver that pushes
// hand-computed expectations, and a monitor that checks each retirement.
module tb_alu_exec_stage;
  import gP::*;

  localparam int EW = 24;  // {wen, dst[2:0], data[15:0], z, n, c, ill}

  logic  CLK = 1'b0;
  logic  RST_N = 1'b0;
  logic  FLAG_Z, FLAG_N, FLAG_C, DONE, ILL;
  exst_t dbgState;

  always #5 CLK = ~CLK;

  alu_exec_stage_if bus ();

  alu_exec_stage dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .bus      (bus),
    .FLAG_Z   (FLAG_Z),
    .FLAG_N   (FLAG_N),
    .FLAG_C   (FLAG_C),
    .DONE     (DONE),
    .ILL      (ILL),
    .dbgState (dbgState)
  );

  // ---------------- clock counter and register-file model ----------------
  int          cyc = 0;
  logic [15:0] rf [8];
  logic        preEn = 1'b0;
  logic [2:0]  preAddr = '0;
  logic [15:0] preData = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  assign bus.S1_Out = rf[bus.RegS1];
  assign bus.S2_Out = rf[bus.RegS2];

  always @(posedge CLK) begin
    if (bus.WEN) rf[bus.WrtDst] <= bus.WriteData;
    if (preEn)   rf[preAddr]    <= preData;
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int            expCyc_q[$];
  int            checks = 0;
  int            failures = 0;
  logic          abortWin = 1'b0;
  logic          wenSeen = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (abortWin && bus.WEN) wenSeen = 1'b1;
  end

  always @(negedge CLK) begin
    logic [EW-1:0] e;
    int            ec;
    if (RST_N) begin
      check("pulse_needs_done", {31'd0, (bus.WEN || ILL) && !DONE}, 32'd0);
      if (DONE) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e  = exp_q.pop_front();
          ec = expCyc_q.pop_front();
          check("wen", {31'd0, bus.WEN}, {31'd0, e[23]});
          if (e[23]) begin
            check("wrtdst", {29'd0, bus.WrtDst}, {29'd0, e[22:20]});
            check("wdata", {16'd0, bus.WriteData}, {16'd0, e[19:4]});
          end
          check("flags_znc", {29'd0, FLAG_Z, FLAG_N, FLAG_C}, {29'd0, e[3:1]});
          check("ill", {31'd0, ILL}, {31'd0, e[0]});
          check("retire_cycle", cyc, ec);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preset(input logic [2:0] a, input logic [15:0] d);
    @(negedge CLK);
    preEn = 1'b1; preAddr = a; preData = d;
    @(posedge CLK);
    #1 preEn = 1'b0;
  endtask

  // Presents one instruction and pushes its expected retirement when 'track' is set.
  task automatic issue(input logic [3:0] opc, input logic [2:0] dst, input logic [2:0] sa1,
                       input logic [2:0] sa2, input logic expWen, input logic [15:0] expData,
                       input logic [2:0] expZnc, input logic expIll, input logic track,
                       input logic holdVld, output int waited);
    int w = 0;
    @(negedge CLK);
    bus.IN_VLD = 1'b1; bus.OPC = opc; bus.DST = dst; bus.SA1 = sa1; bus.SA2 = sa2;
    while (!bus.IN_RDY && w < 40) begin
      @(negedge CLK);
      w++;
    end
    waited = w;
    if (w >= 40) begin
      check("accept_timeout", 32'd1, 32'd0);
      bus.IN_VLD = 1'b0;
      return;
    end
    if (track) begin
      exp_q.push_back({expWen, dst, expData, expZnc, expIll});
      expCyc_q.push_back(cyc + ((opc == OPC_MUL) ? 18 : 2));
    end
    @(posedge CLK);
    if (!holdVld) #1 bus.IN_VLD = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge CLK);
      w++;
    end
    if (w >= 100) check("drain_timeout", 32'd1, 32'd0);
    @(negedge CLK);
  endtask

  task automatic checkZeroOutputs(input string name);
    check(name, {8'd0, bus.WEN, DONE, ILL, FLAG_Z, FLAG_N, FLAG_C, bus.WrtDst, bus.WriteData},
          32'd0);
    check({name, "_regs"}, {26'd0, bus.RegS1, bus.RegS2}, 32'd0);
    check({name, "_in_rdy"}, {31'd0, bus.IN_RDY}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    bus.IN_VLD = 1'b0; bus.OPC = '0; bus.DST = '0; bus.SA1 = '0; bus.SA2 = '0;
    repeat (3) @(negedge CLK);
    checkZeroOutputs("reset");
    RST_N = 1'b1;

    // ADD 5+7 into r3
    preset(3'd1, 16'h0005); preset(3'd2, 16'h0007);
    issue(OPC_ADD, 3'd3, 3'd1, 3'd2, 1'b1, 16'h000C, 3'b000, 1'b0, 1'b1, 1'b0, w);
    drain();
    // ADD wrap: FFFF+0001
    preset(3'd4, 16'hFFFF); preset(3'd5, 16'h0001);
    issue(OPC_ADD, 3'd6, 3'd4, 3'd5, 1'b1, 16'h0000, 3'b101, 1'b0, 1'b1, 1'b0, w);
    drain();
    // SUB 1-2 into r0, then dependent logic ops back to back
    preset(3'd2, 16'h0002);
    issue(OPC_SUB, 3'd0, 3'd5, 3'd2, 1'b1, 16'hFFFF, 3'b011, 1'b0, 1'b1, 1'b0, w);
    issue(OPC_AND, 3'd7, 3'd4, 3'd2, 1'b1, 16'h0002, 3'b000, 1'b0, 1'b1, 1'b0, w);
    issue(OPC_OR,  3'd1, 3'd0, 3'd2, 1'b1, 16'hFFFF, 3'b010, 1'b0, 1'b1, 1'b0, w);
    issue(OPC_XOR, 3'd2, 3'd1, 3'd4, 1'b1, 16'h0000, 3'b100, 1'b0, 1'b1, 1'b0, w);
    drain();
    // shifts, NOT, and flag-preserving MOV/NOP
    preset(3'd3, 16'h8001);
    issue(OPC_SHL, 3'd5, 3'd3, 3'd0, 1'b1, 16'h0002, 3'b001, 1'b0, 1'b1, 1'b0, w);
    issue(OPC_SHR, 3'd6, 3'd3, 3'd0, 1'b1, 16'h4000, 3'b001, 1'b0, 1'b1, 1'b0, w);
    issue(OPC_NOT, 3'd4, 3'd6, 3'd0, 1'b1, 16'hBFFF, 3'b010, 1'b0, 1'b1, 1'b0, w);
    issue(OPC_MOV, 3'd7, 3'd3, 3'd0, 1'b1, 16'h8001, 3'b010, 1'b0, 1'b1, 1'b0, w);
    issue(OPC_NOP, 3'd2, 3'd0, 3'd0, 1'b0, 16'h0000, 3'b010, 1'b0, 1'b1, 1'b0, w);
    drain();
    // MUL 0x0100 * 0x0100 overflows the low half entirely
    preset(3'd1, 16'h0100); preset(3'd2, 16'h0100);
    issue(OPC_MUL, 3'd3, 3'd1, 3'd2, 1'b1, 16'h0000, 3'b101, 1'b0, 1'b1, 1'b0, w);
    drain();
    // MUL 3*5 with IN_VLD held high; the following AND must wait for IDLE
    preset(3'd1, 16'h0003); preset(3'd2, 16'h0005);
    issue(OPC_MUL, 3'd4, 3'd1, 3'd2, 1'b1, 16'h000F, 3'b000, 1'b0, 1'b1, 1'b1, w);
    issue(OPC_AND, 3'd5, 3'd1, 3'd2, 1'b1, 16'h0001, 3'b000, 1'b0, 1'b1, 1'b0, w);
    check("mul_busy_cycles", w, 18);
    drain();
    // CMP r1,r1 and an illegal opcode: no writes, flags kept by ILL
    issue(OPC_CMP, 3'd6, 3'd1, 3'd1, 1'b0, 16'h0000, 3'b100, 1'b0, 1'b1, 1'b0, w);
    issue(4'hC,    3'd2, 3'd1, 3'd2, 1'b0, 16'h0000, 3'b100, 1'b1, 1'b1, 1'b0, w);
    drain();
    check("cmp_kept_r6", {16'd0, rf[6]}, 32'h0000_4000);

    // reset in the middle of a MUL aborts it without a write
    abortWin = 1'b1;
    issue(OPC_MUL, 3'd6, 3'd1, 3'd2, 1'b0, 16'h0000, 3'b000, 1'b0, 1'b0, 1'b0, w);
    repeat (9) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    checkZeroOutputs("abort_reset");
    RST_N = 1'b1;
    repeat (20) @(negedge CLK);
    check("abort_no_wen", {31'd0, wenSeen}, 32'd0);
    check("abort_in_rdy", {31'd0, bus.IN_RDY}, 32'd1);
    check("abort_r6", {16'd0, rf[6]}, 32'h0000_4000);
    abortWin = 1'b0;

    // stage works normally after the abort
    issue(OPC_ADD, 3'd7, 3'd1, 3'd2, 1'b1, 16'h0008, 3'b000, 1'b0, 1'b1, 1'b0, w);
    drain();
    check("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
